p8_fp32: RTL and testbench
==========================

# p8_fp32

Streaming posit⟨8,0⟩ to IEEE-754 binary32 decoder. It is the inverse of the block that converts fp32 to posit8. It accepts one posit8 word per valid/ready transfer and returns the exactly equal fp32 word two pipeline stages later, with full backpressure. It sits on the read-back path of the posit unit, where posit results are widened for fp32 consumers. It also keeps a saturating count of NaR inputs for debug.

## Interface
- No parameters. Widths are fixed: posit 8 bits, es = 0, fp32 32 bits.
- `clk  in  1` — the only clock; all state updates on its rising edge.
- `rst_n  in  1` — reset, asynchronous and active-low.
- `in_valid  in  1` — `in_p8` holds a word to transfer.
- `in_ready  out  1` — the block accepts a word this cycle.
- `in_p8  in  8` — posit8 word, two's-complement encoded.
- `out_valid  out  1` — `out_fp32` is valid.
- `out_ready  in  1` — downstream accepts `out_fp32` this cycle.
- `out_fp32  out  32` — decoded binary32 word.
- `nar_clr  in  1` — synchronous clear of `nar_cnt`.
- `nar_cnt  out  8` — saturating count of NaR words accepted.

## Operation
- **Input transfer:** occurs when `in_valid & in_ready`. **Output transfer:** occurs when `out_valid & out_ready`.
- **Stage 1 (S1)** registers:
  - sign = `p[7]`;
  - magnitude m = `p[7] ? (~p+1) : p`, 8 bits;
  - `is_zero` = (p == 0x00);
  - `is_nar` = (p == 0x80).
- **Stage 2 (S2)** registers the assembled fp32 word, computed from S1:
  - Regime: r0 = `m[6]`. run = number of consecutive bits equal to r0, scanning from `m[6]` downward, range 1..7.
  - k = r0 ? run−1 : −run, giving range −6..+6.
  - The terminating bit, if present, sits at position 6−run and is skipped.
  - Fraction bits are `m[5−run:0]`; there are max(0, 6−run) of them.
  - Fraction is left-aligned into mantissa `[22:0]`; remaining bits are zero.
  - exponent = k + 127, 8-bit unsigned, range 121..133. There are no subnormals and no rounding: every posit8 value is exact in fp32.
  - `out_fp32` = {sign, exponent, mantissa}.
- **Specials** override the normal assembly:
  - `is_zero` → 0x00000000.
  - `is_nar` → 0x7FC00000 (canonical quiet NaN, sign 0).
- **Flow control:**
  - s2_adv = ~S2.valid | out_ready.
  - s1_adv = ~S1.valid | s2_adv.
  - `in_ready` = s1_adv. This is combinational from `out_ready`; no skid buffer.
  - S2 loads from S1 when s2_adv. S2.valid ← S1.valid.
  - S1 loads from the input when s1_adv. S1.valid ← in_valid.
  - Data registers hold their value while stalled. `out_fp32` is stable while `out_valid & ~out_ready`.
- **NaR counter:**
  - Increments on each input transfer where `in_p8` == 0x80, saturating at 0xFF.
  - `nar_clr` has priority: the counter becomes 0 even if a NaR transfers in the same cycle.
- **Reset values:** S1.valid = S2.valid = 0, `out_valid` = 0, `out_fp32` = 0x00000000, `nar_cnt` = 0x00. `in_ready` = 1 right after reset.
- **Reset mid-operation:** in-flight words are discarded. No output transfer happens in the cycle reset is asserted.

## Timing
- Latency is 2 cycles. A word accepted at edge n is presented with `out_valid` = 1 after edge n+2, provided there is no stall.
- Throughput is 1 word/cycle while `out_ready` = 1.
- With `out_ready` held 0, the block absorbs at most 2 words. `in_ready` falls once both stages are full.
- Simultaneous input and output transfer on a full pipe is allowed; occupancy stays the same.
- `nar_cnt` updates on the edge of the accepting transfer. It is visible the next cycle.

## Test plan
- **Exhaustive values:** send all 256 inputs back-to-back with `out_ready` = 1. Spot checks:
  - 0x40 → 0x3F800000;
  - 0x50 → 0x3FC00000;
  - 0x60 → 0x40000000;
  - 0x20 → 0x3F000000;
  - 0x30 → 0x3F400000;
  - 0x01 → 0x3C800000;
  - 0x7F → 0x42800000;
  - 0xC0 → 0xBF800000;
  - 0x81 → 0xC2800000.
  - Output order and count must match the input; each result must appear exactly 2 cycles after its input.
- **Specials:** 0x00 → 0x00000000; 0x80 → 0x7FC00000; `nar_cnt` increments by 1.
- **Backpressure:** stream 0x40, 0x60, 0x20 with `out_ready` = 0 for 5 cycles.
  - `in_ready` deasserts after 2 accepts.
  - `out_fp32` holds 0x3F800000 throughout the stall.
  - After release, outputs are 0x3F800000, 0x40000000, 0x3F000000, with no loss or duplicates.
- **NaR counter:** send 300 NaR words → `nar_cnt` = 0xFF. Then assert `nar_clr` together with a NaR transfer → 0x00.
- **Reset mid-stream:** drop `rst_n` asynchronously with 2 words in flight.
  - `out_valid` = 0 and `nar_cnt` = 0 immediately.
  - After release, the first new input 0x50 emerges as 0x3FC00000.
- **Random stress:** random `in_valid` and `out_ready`. A scoreboard compares every output against a reference model, in order.

Source files
------------

// File: rtl/p8_fp32.sv
// ============================================================================
// p8_fp32 : streaming posit<8,0> to IEEE-754 binary32 decoder, 2-stage
//           valid/ready pipeline with a saturating NaR counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module p8_fp32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_p8,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_fp32,
    input  logic        nar_clr,
    output logic [7:0]  nar_cnt
);

    localparam logic [7:0]  C_NAR      = 8'h80;
    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  C_CNT_MAX  = 8'hFF;

    // Stage 1: sign / magnitude split and special-value flags
    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_mag;
    logic        s1_zero;
    logic        s1_nar;

    // Stage 2: assembled binary32 word
    logic        s2_valid;
    logic [31:0] s2_word;

    logic        s2_adv;
    logic        s1_adv;
    logic        in_xfer;

    logic        r0;
    logic [2:0]  run;
    logic        run_done;
    logic [5:0]  frac;
    logic [7:0]  exp_b;
    logic [31:0] word;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid & s1_adv;

    assign out_valid = s2_valid;
    assign out_fp32  = s2_word;

    // Regime run length: bits equal to m[6], scanning downward (1..7).
    assign r0 = s1_mag[6];

    always_comb begin
        run      = 3'd1;
        run_done = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (!run_done && (s1_mag[i] == r0)) begin
                run = run + 3'd1;
            end else begin
                run_done = 1'b1;
            end
        end
    end

    // Shifting by run drops the regime and terminator, leaving the fraction
    // left-aligned; runs of 6 or 7 leave no fraction bits at all.
    assign frac  = s1_mag[5:0] << run;
    assign exp_b = r0 ? (8'd126 + {5'd0, run}) : (8'd127 - {5'd0, run});

    always_comb begin
        word = {s1_sign, exp_b, frac, 17'd0};
        if (s1_zero) begin
            word = 32'd0;
        end else if (s1_nar) begin
            word = C_QNAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 8'd0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_p8[7];
                s1_mag  <= in_p8[7] ? (~in_p8 + 8'd1) : in_p8;
                s1_zero <= (in_p8 == 8'h00);
                s1_nar  <= (in_p8 == C_NAR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_word  <= 32'd0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= word;
            end
        end
    end

    // Clear wins over a same-cycle NaR transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nar_cnt <= 8'd0;
        end else if (nar_clr) begin
            nar_cnt <= 8'd0;
        end else if (in_xfer && (in_p8 == C_NAR) && (nar_cnt != C_CNT_MAX)) begin
            nar_cnt <= nar_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_p8_fp32.sv
// ============================================================================
// tb_p8_fp32 : self-checking bench for p8_fp32 with a real-valued posit model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_p8_fp32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_p8;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp32;
    logic        nar_clr;
    logic [7:0]  nar_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        last_in;
    logic        last_out;
    logic        last_ovalid;
    logic [31:0] last_oword;

    logic [7:0]  sent_q[$];
    int          sent_cyc[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];

    p8_fp32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p8     (in_p8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp32  (out_fp32),
        .nar_clr   (nar_clr),
        .nar_cnt   (nar_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posit value computed as a real number, then re-encoded as binary32.
    function automatic logic [31:0] ref_fp32(input logic [7:0] p);
        int  v, first, run, i, k, nf, fbits, e, mant;
        real val;
        bit  s;
        if (p == 8'h00) return 32'h0000_0000;
        if (p == 8'h80) return 32'h7FC0_0000;
        s = p[7];
        v = s ? (256 - int'(p)) : int'(p);
        first = (v >> 6) & 1;
        run = 0;
        i = 6;
        while (i >= 0 && ((v >> i) & 1) == first) begin
            run++;
            i--;
        end
        k = first ? run - 1 : -run;
        nf = (i > 0) ? i : 0;
        fbits = v & ((1 << nf) - 1);
        val = 1.0 + real'(fbits) / real'(1 << nf);
        for (int j = 0; j < k; j++) val = val * 2.0;
        for (int j = 0; j < -k; j++) val = val / 2.0;
        e = 0;
        while (val >= 2.0) begin val = val / 2.0; e++; end
        while (val < 1.0)  begin val = val * 2.0; e--; end
        mant = $rtoi((val - 1.0) * 8388608.0);
        return {s, 8'(e + 127), 23'(mant)};
    endfunction

    task automatic cycle();
        @(negedge clk);
        last_in     = in_valid && in_ready;
        last_out    = out_valid && out_ready;
        last_ovalid = out_valid;
        last_oword  = out_fp32;
        if (last_in) begin
            sent_q.push_back(in_p8);
            sent_cyc.push_back(cyc);
        end
        if (last_out) begin
            obs_q.push_back(out_fp32);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_queues();
        sent_q.delete(); sent_cyc.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_fp32 !== 32'h0) begin errors++; $display("FAIL reset_out_fp32 got %h exp 00000000", out_fp32); end
        checks++;
        if (nar_cnt !== 8'h0) begin errors++; $display("FAIL reset_nar_cnt got %h exp 00", nar_cnt); end
    endtask

    task automatic test_exhaustive();
        logic [7:0]  sp_in[11]  = '{8'h40, 8'h50, 8'h60, 8'h20, 8'h30, 8'h01, 8'h7F, 8'hC0, 8'h81, 8'h00, 8'h80};
        logic [31:0] sp_out[11] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h3F400000,
                                    32'h3C800000, 32'h42800000, 32'hBF800000, 32'hC2800000, 32'h00000000,
                                    32'h7FC00000};
        clear_queues();
        out_ready = 1'b1;
        for (int p = 0; p < 256; p++) begin
            in_valid = 1'b1;
            in_p8    = 8'(p);
            cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        checks++;
        if (obs_q.size() != 256 || sent_q.size() != 256) begin
            errors++;
            $display("FAIL exh_count got out %0d in %0d exp 256", obs_q.size(), sent_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (obs_q[i] !== ref_fp32(sent_q[i])) begin
                    errors++;
                    $display("FAIL exh_value in %h got %h exp %h", sent_q[i], obs_q[i], ref_fp32(sent_q[i]));
                end
                checks++;
                if (obs_cyc[i] - sent_cyc[i] != 2) begin
                    errors++;
                    $display("FAIL exh_latency in %h got %0d exp 2", sent_q[i], obs_cyc[i] - sent_cyc[i]);
                end
            end
            for (int j = 0; j < 11; j++) begin
                checks++;
                if (obs_q[sp_in[j]] !== sp_out[j]) begin
                    errors++;
                    $display("FAIL spot_%h got %h exp %h", sp_in[j], obs_q[sp_in[j]], sp_out[j]);
                end
            end
        end
        checks++;
        if (nar_cnt !== 8'h01) begin errors++; $display("FAIL exh_nar_cnt got %h exp 01", nar_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  words[3]   = '{8'h40, 8'h60, 8'h20};
        logic [31:0] expect3[3] = '{32'h3F800000, 32'h40000000, 32'h3F000000};
        int idx = 0;
        clear_queues();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            in_p8    = words[idx % 3];
            cycle();
            if (last_in) idx++;
            if (c >= 2) begin
                checks++;
                if (!last_ovalid || last_oword !== 32'h3F800000) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d got v=%b %h exp v=1 3f800000", c, last_ovalid, last_oword);
                end
            end
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL bp_accepts got %0d exp 2", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 3);
            in_p8    = words[idx % 3];
            cycle();
            if (last_in) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL bp_out_count got %0d exp 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== expect3[i]) begin
                    errors++;
                    $display("FAIL bp_out_%0d got %h exp %h", i, obs_q[i], expect3[i]);
                end
            end
        end
    endtask

    task automatic test_nar_counter();
        clear_queues();
        out_ready = 1'b1;
        nar_clr   = 1'b1;
        in_valid  = 1'b0;
        cycle();
        nar_clr = 1'b0;
        checks++;
        if (nar_cnt !== 8'h00) begin errors++; $display("FAIL nar_clear_idle got %h exp 00", nar_cnt); end
        in_valid = 1'b1;
        in_p8    = 8'h80;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (i == 254) begin
                checks++;
                if (nar_cnt !== 8'hFF) begin errors++; $display("FAIL nar_reach_ff got %h exp ff", nar_cnt); end
            end
        end
        checks++;
        if (nar_cnt !== 8'hFF) begin errors++; $display("FAIL nar_saturate got %h exp ff", nar_cnt); end
        nar_clr = 1'b1;
        cycle();
        checks++;
        if (!last_in) begin errors++; $display("FAIL nar_clr_xfer got 0 exp 1"); end
        nar_clr  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (nar_cnt !== 8'h00) begin errors++; $display("FAIL nar_clr_priority got %h exp 00", nar_cnt); end
        repeat (3) cycle();
        checks++;
        if (obs_q.size() != 301 || obs_q[0] !== 32'h7FC00000) begin
            errors++;
            $display("FAIL nar_outputs got n=%0d exp 301 qnan", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] words[2] = '{8'h80, 8'h40};
        int t0;
        clear_queues();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_p8    = words[i];
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || nar_cnt !== 8'h01) begin
            errors++;
            $display("FAIL rst_precond got v=%b cnt=%h exp v=1 cnt=01", out_valid, nar_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); end
        checks++;
        if (nar_cnt !== 8'h00) begin errors++; $display("FAIL rst_mid_nar_cnt got %h exp 00", nar_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_queues();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_p8     = 8'h50;
        cycle();
        in_valid = 1'b0;
        t0 = sent_cyc.size() > 0 ? sent_cyc[0] : -1;
        repeat (4) cycle();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h3FC00000 || obs_cyc[0] - t0 != 2) begin
            errors++;
            $display("FAIL rst_mid_first got n=%0d %h exp 1 3fc00000 at +2",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        logic [7:0]  exp_in[$];
        logic [31:0] got;
        logic [7:0]  src;
        clear_queues();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_p8     = 8'($urandom);
            cycle();
            if (last_in) exp_in.push_back(sent_q.pop_front());
            if (last_out) begin
                got = obs_q.pop_front();
                checks++;
                if (exp_in.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious got %h exp none", got);
                end else begin
                    src = exp_in.pop_front();
                    if (got !== ref_fp32(src)) begin
                        errors++;
                        $display("FAIL rnd_value in %h got %h exp %h", src, got, ref_fp32(src));
                    end
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_out) begin
                got = obs_q.pop_front();
                checks++;
                if (exp_in.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_drain_spurious got %h exp none", got);
                end else begin
                    src = exp_in.pop_front();
                    if (got !== ref_fp32(src)) begin
                        errors++;
                        $display("FAIL rnd_drain in %h got %h exp %h", src, got, ref_fp32(src));
                    end
                end
            end
        end
        checks++;
        if (exp_in.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending exp 0", exp_in.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_p8     = 8'h00;
        out_ready = 1'b0;
        nar_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_exhaustive();
        test_backpressure();
        test_nar_counter();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
